conv_pool_drain: RTL

//  Sits directly downstream of the convolution result FIFO and is the sole driver
//  of that FIFO's command port. Merges upstream write requests with its own reads,

---
 rtl/conv_pool_drain.sv | 111 +++++++++++
 1 files changed

// File: rtl/conv_pool_drain.sv
// Drains signed convolution results from the upstream FIFO, max-pools each window of
// POOL_SIZE samples (optional ReLU) and offers the result on a valid/ready handshake.
module conv_pool_drain #(
  parameter int unsigned DATA_WIDTH = 20,
  parameter int unsigned POOL_SIZE  = 4,
  parameter bit          RELU_EN    = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_req,
  output logic                  wr_ack,
  input  logic [1:0]            fifo_status,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic [1:0]            fifo_cmd,
  output logic [DATA_WIDTH-1:0] pool_out,
  output logic                  pool_valid,
  input  logic                  pool_ready
);

  localparam int unsigned CNT_W = $clog2(POOL_SIZE + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_WAIT = 2'd2,
    ST_EMIT = 2'd3
  } state_e;

  state_e                        state_q, state_d;
  logic        [CNT_W-1:0]       count_q, count_d;
  logic signed [DATA_WIDTH-1:0]  max_q, max_d;
  logic signed [DATA_WIDTH-1:0]  pool_out_q, pool_out_d;
  logic                          pool_valid_q, pool_valid_d;

  logic                          fifo_full, fifo_empty;
  logic                          wr_grant, rd_issue;
  logic        [CNT_W-1:0]       count_inc;
  logic signed [DATA_WIDTH-1:0]  sample, max_upd, relu_val;

  assign fifo_full  = fifo_status[1];
  assign fifo_empty = fifo_status[0];

  // Command arbitration: writes beat reads, nothing is issued while in reset.
  always_comb begin
    wr_grant = reset && wr_req && !fifo_full;
    rd_issue = reset && !wr_grant && (state_q == ST_READ) && !fifo_empty;
    fifo_cmd = {wr_grant, rd_issue};
    wr_ack   = wr_grant;
  end

  // Running-max datapath; the first sample of a window loads unconditionally, ties keep the max.
  always_comb begin
    sample    = $signed(fifo_data);
    count_inc = count_q + CNT_W'(1);
    max_upd   = ((count_q == '0) || (sample > max_q)) ? sample : max_q;
    relu_val  = (RELU_EN && max_upd[DATA_WIDTH-1]) ? '0 : max_upd;
  end

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    max_d        = max_q;
    pool_out_d   = pool_out_q;
    pool_valid_d = pool_valid_q;
    case (state_q)
      ST_IDLE: state_d = ST_READ;
      ST_READ: begin
        if (rd_issue) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        max_d = max_upd;
        if (count_inc == CNT_W'(POOL_SIZE)) begin
          count_d      = '0;
          pool_out_d   = relu_val;
          pool_valid_d = 1'b1;
          state_d      = ST_EMIT;
        end else begin
          count_d = count_inc;
          state_d = ST_READ;
        end
      end
      ST_EMIT: begin
        if (pool_ready) begin
          pool_valid_d = 1'b0;
          state_d      = ST_READ;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      count_q      <= '0;
      max_q        <= '0;
      pool_out_q   <= '0;
      pool_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      max_q        <= max_d;
      pool_out_q   <= pool_out_d;
      pool_valid_q <= pool_valid_d;
    end
  end

  assign pool_out   = pool_out_q;
  assign pool_valid = pool_valid_q;

endmodule
